seq_num_alloc: RTL and testbench

Allocates sequence numbers to instructions at dispatch and tracks the in-flight window from oldest (head) to next-to-allocate (tail). Frees numbers in order as commit notifications arrive. On the granted squash from the level-1 squash arbiter, rolls tail back so that all instructions younger than the squashing instruction are discarded. Sits between dispatch, the commit notification bus and the squash grant bus, and is the single source of the seq_num values that the squash arbiter compares by age.

---
 rtl/seq_num_alloc.sv | 176 +++++++++++++++++
 tb/tb_seq_num_alloc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_num_alloc.sv
// Sequence-number allocator.
// Hands out sequence numbers to dispatching instructions and tracks the
// in-flight window from the oldest number (head) to the next free number
// (tail). Numbers are retired strictly in order by commit notifications.
// A granted squash trims the window back to the squashing instruction,
// which itself stays in flight.
//
// Full and empty are told apart only by the occupancy count. Head and tail
// are equal in both cases, so comparing them would be ambiguous.

module seq_num_alloc #(
    parameter int p_seq_num_bits = 5,
    parameter int p_max_inflight = 2 ** p_seq_num_bits
) (
    input  logic                      clk,
    input  logic                      rst,

    // Dispatch side
    input  logic                      alloc_val,
    output logic                      alloc_rdy,
    output logic [p_seq_num_bits-1:0] alloc_seq_num,

    // Commit notification bus
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num,

    // Granted squash from the squash arbiter
    input  logic                      squash_val,
    input  logic [p_seq_num_bits-1:0] squash_seq_num,

    // Window status
    output logic [p_seq_num_bits-1:0] head_seq_num,
    output logic [p_seq_num_bits:0]   inflight_count,
    output logic                      empty,
    output logic                      err
);

    localparam int NB = p_seq_num_bits;

    // Occupancy limit, held at the width of the count register.
    localparam logic [NB:0] MAX_COUNT = (NB + 1)'(p_max_inflight);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [NB-1:0] head_q,  head_d;
    logic [NB-1:0] tail_q,  tail_d;
    logic [NB:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          err_q,   err_d;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic          slot_free;
    logic          alloc_fire;
    logic          window_nonempty;
    logic          commit_legal;
    logic          commit_bad;
    logic [NB-1:0] squash_dist;
    logic [NB:0]   squash_dist_ext;
    logic [NB:0]   squash_span;
    logic          squash_legal;
    logic          squash_bad;
    logic [NB:0]   commit_dec;

    // Allocation is gated on the registered count only. A same-cycle commit
    // does not open a slot for a same-cycle allocation. A squash in flight
    // blocks dispatch, because tail is being rewritten this cycle.
    always_comb begin
        slot_free  = (count_q < MAX_COUNT);
        alloc_rdy  = !rst && slot_free && !squash_val;
        alloc_fire = alloc_val && alloc_rdy;
    end

    // Judge commit and squash legality against the pre-cycle window.
    always_comb begin
        window_nonempty = (count_q != '0);

        commit_legal = commit_val && window_nonempty && (commit_seq_num == head_q);
        commit_bad   = commit_val && !commit_legal;

        // Age of the squashing instruction relative to head, modulo the
        // number space. It is inside the window iff that age is below count.
        squash_dist     = squash_seq_num - head_q;
        squash_dist_ext = {1'b0, squash_dist};
        squash_span     = squash_dist_ext + (NB + 1)'(1);
        squash_legal    = squash_val && window_nonempty && (squash_dist_ext < count_q);
        squash_bad      = squash_val && !squash_legal;

        commit_dec = (NB + 1)'(commit_legal);
    end

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------

    // Head advances only on an in-order commit. A squash never moves head,
    // because the squashing instruction itself stays in flight.
    always_comb begin
        head_d = head_q;
        if (commit_legal) begin
            head_d = head_q + NB'(1);
        end
    end

    // A legal squash rewinds tail to just past the squashing instruction.
    // Otherwise tail moves forward on each granted allocation. Both cannot
    // happen together, because alloc_rdy is low whenever squash_val is high.
    always_comb begin
        tail_d = tail_q;
        if (squash_legal) begin
            tail_d = squash_seq_num + NB'(1);
        end else if (alloc_fire) begin
            tail_d = tail_q + NB'(1);
        end
    end

    // Occupancy follows tail. After a squash it is the squashing
    // instruction's age plus one, minus a same-cycle commit. A commit
    // together with an allocation leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (squash_legal) begin
            count_d = squash_span - commit_dec;
        end else begin
            count_d = count_q + (NB + 1)'(alloc_fire) - commit_dec;
        end
    end

    // Keep empty as its own flop so the output comes straight from a register.
    always_comb begin
        empty_d = (count_d == '0);
    end

    // A protocol violation latches the error flag until reset. The offending
    // event is simply ignored, so state is never corrupted.
    always_comb begin
        err_d = err_q || commit_bad || squash_bad;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Synchronous reset wins over every same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Every status output comes directly from a register.
    always_comb begin
        alloc_seq_num  = tail_q;
        head_seq_num   = head_q;
        inflight_count = count_q;
        empty          = empty_q;
        err            = err_q;
    end

endmodule

// File: tb/tb_seq_num_alloc.sv
// Testbench for seq_num_alloc, using a 3-bit number space and a depth of 8.
// The reference model keeps the in-flight window as a queue of actual
// sequence numbers, oldest first. Each step first checks the combinational
// alloc handshake, then checks the registered window state after the edge.

module tb_seq_num_alloc;

    localparam int NB    = 3;
    localparam int MAXF  = 8;
    localparam int SPACE = 8;

    logic          clk;
    logic          rst;
    logic          alloc_val;
    logic          alloc_rdy;
    logic [NB-1:0] alloc_seq_num;
    logic          commit_val;
    logic [NB-1:0] commit_seq_num;
    logic          squash_val;
    logic [NB-1:0] squash_seq_num;
    logic [NB-1:0] head_seq_num;
    logic [NB:0]   inflight_count;
    logic          empty;
    logic          err;

    int testsRun  = 0;
    int failCount = 0;

    // Reference model: the in-flight numbers, oldest first.
    int q[$];
    int nextNum;
    bit expErr;

    seq_num_alloc #(
        .p_seq_num_bits (NB),
        .p_max_inflight (MAXF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_val      (alloc_val),
        .alloc_rdy      (alloc_rdy),
        .alloc_seq_num  (alloc_seq_num),
        .commit_val     (commit_val),
        .commit_seq_num (commit_seq_num),
        .squash_val     (squash_val),
        .squash_seq_num (squash_seq_num),
        .head_seq_num   (head_seq_num),
        .inflight_count (inflight_count),
        .empty          (empty),
        .err            (err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        q.delete();
        nextNum = 0;
        expErr  = 1'b0;
    endtask

    task automatic checkState();
        int expHead;
        expHead = (q.size() > 0) ? q[0] : nextNum;
        checkOutput("head_seq_num",   head_seq_num,   expHead);
        checkOutput("inflight_count", inflight_count, q.size());
        checkOutput("empty",          empty,          q.size() == 0);
        checkOutput("err",            err,            expErr);
    endtask

    // One clock cycle: drive inputs, check the handshake before the edge,
    // update the model at the edge, then check the registered state.
    task automatic applyStimulus(input bit r, input bit av, input bit cv, input int cs,
                                 input bit sv, input int ss);
        bit expRdy;
        bit commitLegal;
        bit squashLegal;
        int idx;
        @(negedge clk);
        rst            = r;
        alloc_val      = av;
        commit_val     = cv;
        commit_seq_num = NB'(cs);
        squash_val     = sv;
        squash_seq_num = NB'(ss);
        #1;
        expRdy = !r && (q.size() < MAXF) && !sv;
        checkOutput("alloc_rdy",     alloc_rdy,     expRdy);
        checkOutput("alloc_seq_num", alloc_seq_num, nextNum);
        @(posedge clk);
        if (r) begin
            modelReset();
        end else begin
            commitLegal = cv && (q.size() > 0) && (q[0] == cs);
            idx = -1;
            if (sv) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i] == ss) idx = i;
                end
            end
            squashLegal = sv && (idx >= 0);
            if (squashLegal) begin
                while (q.size() > idx + 1) void'(q.pop_back());
                nextNum = (ss + 1) % SPACE;
            end else if (av && expRdy) begin
                q.push_back(nextNum);
                nextNum = (nextNum + 1) % SPACE;
            end
            if (commitLegal) void'(q.pop_front());
            if ((cv && !commitLegal) || (sv && !squashLegal)) expErr = 1'b1;
        end
        #1;
        checkState();
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
    endtask

    task automatic doAlloc();
        applyStimulus(0, 1, 0, 0, 0, 0);
    endtask

    task automatic doCommit(input int cs);
        applyStimulus(0, 0, 1, cs, 0, 0);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int cs;
        int ss;
        bit av;
        bit cv;
        bit sv;
        bit r;

        rst = 1'b1; alloc_val = 0; commit_val = 0; commit_seq_num = '0;
        squash_val = 0; squash_seq_num = '0;
        modelReset();
        repeat (2) @(posedge clk);

        // Reset held with all requests active: no grant, window empty.
        applyStimulus(1, 1, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post_reset_rdy", alloc_rdy, 1);
        checkOutput("post_reset_seq", alloc_seq_num, 0);
        checkOutput("post_reset_empty", empty, 1);

        // Three allocations, then fill to capacity.
        for (int i = 0; i < 3; i++) doAlloc();
        checkOutput("three_count", inflight_count, 3);
        checkOutput("three_head", head_seq_num, 0);
        checkOutput("three_empty", empty, 0);
        for (int i = 0; i < 5; i++) doAlloc();
        checkOutput("full_count", inflight_count, 8);
        // Commit 0 with alloc requested: the freed slot is not reusable yet.
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("full_commit_count", inflight_count, 7);
        checkOutput("wrap_grant_seq", alloc_seq_num, 0);
        doAlloc();
        checkOutput("wrap_grant_count", inflight_count, 8);

        // Alloc 0..5, then squash 2 with alloc requested in the same cycle.
        doReset();
        for (int i = 0; i < 6; i++) doAlloc();
        applyStimulus(0, 1, 0, 0, 1, 2);
        checkOutput("squash_tail", alloc_seq_num, 3);
        checkOutput("squash_count", inflight_count, 3);

        // Alloc 0..3, then commit 0 and squash 0 together.
        doReset();
        for (int i = 0; i < 4; i++) doAlloc();
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("cs_count", inflight_count, 0);
        checkOutput("cs_empty", empty, 1);
        checkOutput("cs_head", head_seq_num, 1);
        checkOutput("cs_next_seq", alloc_seq_num, 1);

        // Wrap-around: allocate and commit ten numbers in order.
        doReset();
        for (int i = 0; i < 10; i++) begin
            doAlloc();
            doCommit(i % SPACE);
        end
        checkOutput("wrap_head", head_seq_num, 2);
        checkOutput("wrap_err", err, 0);

        // Protocol violations.
        doReset();
        for (int i = 0; i < 4; i++) doAlloc();
        doCommit(0);
        doCommit(4);
        checkOutput("badcommit_err", err, 1);
        checkOutput("badcommit_head", head_seq_num, 1);
        checkOutput("badcommit_count", inflight_count, 3);
        applyStimulus(0, 0, 0, 0, 1, 6);
        checkOutput("badsquash_tail", alloc_seq_num, 4);
        checkOutput("badsquash_err", err, 1);
        doCommit(1);
        doCommit(2);
        doCommit(3);
        applyStimulus(0, 0, 0, 0, 1, 3);
        checkOutput("emptysquash_count", inflight_count, 0);
        checkOutput("emptysquash_tail", alloc_seq_num, 4);

        // Randomized traffic, mostly legal, with occasional bad events and resets.
        doReset();
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 79) == 0);
            av = ($urandom_range(0, 2) != 0);
            cv = ($urandom_range(0, 2) == 0);
            sv = ($urandom_range(0, 7) == 0);
            cs = $urandom_range(0, SPACE - 1);
            if (q.size() > 0 && $urandom_range(0, 9) != 0) cs = q[0];
            ss = $urandom_range(0, SPACE - 1);
            if (q.size() > 0 && $urandom_range(0, 5) != 0) ss = q[$urandom_range(0, q.size() - 1)];
            if ($urandom_range(0, 29) != 0 && n > 300) begin
                // Keep the second half mostly error-free after a reset.
                if (q.size() == 0) begin
                    cv = 0;
                    sv = 0;
                end
            end
            applyStimulus(r, av, cv, cs, sv, ss);
        end

        // Reset mid-operation with every request active.
        for (int i = 0; i < 3; i++) doAlloc();
        applyStimulus(1, 1, 1, head_seq_num, 1, head_seq_num);
        checkOutput("midreset_count", inflight_count, 0);
        checkOutput("midreset_seq", alloc_seq_num, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
